// File: rtl/sram16_burst_responder.sv
// sram16_burst_responder: serves BURST_LENGTH-word read/write bursts from a 256K x 16 async SRAM.
// Optional feature macro SRAM_POWERDOWN_EN: when defined, chip enable is released while idle.
module sram16_burst_responder #(
    parameter int BURST_LENGTH = 8,
    parameter int WAIT_STATES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic [15:0] to_mem,
    output logic [15:0] from_mem,
    input  logic        mem_req,
    input  logic        mem_wren,
    output logic        mem_ready,
    output logic        mem_valid,
    output logic [2:0]  mem_offset,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    typedef enum logic [2:0] {IDLE, ACCEPT, RSETUP, RSTROBE, WLATCH, WSTROBE, WRECOVER} state_t;
    state_t state, next;
    logic [17:0] base;
    logic        dir;
    logic [3:0]  k;
    logic [3:0]  cnt;
    logic        rvalid;
    logic        last, rdone, wdone;
    logic        unused_addr;
    assign unused_addr = ^mem_address[31:18];
    assign last  = k == 4'(BURST_LENGTH - 1);
    // read strobe spans the access window plus one sample cycle so a read word costs the same as a write word
    assign rdone = cnt == 4'(WAIT_STATES + 1);
    assign wdone = cnt == 4'(WAIT_STATES);
    // state register; async reset aborts any burst immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    // next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = mem_req ? ACCEPT : IDLE;
            ACCEPT:   next = dir ? WLATCH : RSETUP;
            RSETUP:   next = RSTROBE;
            RSTROBE:  next = rdone ? (last ? IDLE : RSETUP) : RSTROBE;
            WLATCH:   next = WSTROBE;
            WSTROBE:  next = wdone ? WRECOVER : WSTROBE;
            WRECOVER: next = last ? IDLE : WLATCH;
            default:  next = IDLE;
        endcase
    end
    // burst context, strobe timer and data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base        <= '0;
            dir         <= 1'b0;
            k           <= '0;
            cnt         <= '0;
            rvalid      <= 1'b0;
            from_mem    <= '0;
            sram_dq_out <= '0;
        end else begin
            cnt    <= (next == state) ? cnt + 4'd1 : 4'd0;
            rvalid <= state == RSTROBE && rdone;
            if (state == IDLE && mem_req) begin
                base <= mem_address[17:0];
                dir  <= mem_wren;
                k    <= '0;
            end
            if (state == RSTROBE && rdone) begin
                from_mem <= sram_dq_in;
                k        <= k + 4'd1;
            end
            if (state == WRECOVER) k <= k + 4'd1;
            if (state == WLATCH) sram_dq_out <= to_mem;
        end
    end
    // outputs decoded from state; read and write strobe sets are disjoint so oe_n and dq_oe never overlap
    always_comb begin
        mem_ready  = state == ACCEPT;
        mem_valid  = rvalid || state == WRECOVER;
        mem_offset = !mem_valid ? 3'd0 : (state == WRECOVER) ? 3'(k + 4'd1) : 3'(k - 4'd1);
        sram_addr  = base + {14'd0, k};
        sram_oe_n  = !(state == RSETUP || state == RSTROBE);
        sram_we_n  = state != WSTROBE;
        sram_dq_oe = state == WSTROBE || state == WRECOVER;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
`ifdef SRAM_POWERDOWN_EN
        sram_ce_n  = state == IDLE;
`else
        sram_ce_n  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_sram16_burst_responder.sv
// tb_sram16_burst_responder: scoreboard bench with SRAM model and reference memory for sram16_burst_responder.
module tb_sram16_burst_responder;
    localparam int BL = 8;
    localparam int WS = 1;
`ifdef SRAM_POWERDOWN_EN
    localparam int CE_IDLE = 1;
`else
    localparam int CE_IDLE = 0;
`endif
    logic        clk, reset;
    logic [31:0] mem_address;
    logic [15:0] to_mem, from_mem, sram_dq_in, sram_dq_out;
    logic        mem_req, mem_wren, mem_ready, mem_valid, sram_dq_oe;
    logic [2:0]  mem_offset;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram16_burst_responder #(.BURST_LENGTH(BL), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .mem_address(mem_address), .to_mem(to_mem), .from_mem(from_mem),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_offset(mem_offset), .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int kind; int off; logic [15:0] data; int lat;} ev_t;
    typedef struct {logic [17:0] a; logic [15:0] d;} wr_t;
    ev_t         exp_q[$];
    wr_t         expw_q[$];
    logic [15:0] fifo[$];
    logic [15:0] ref_w[int];
    logic [15:0] sram[0:262143];
    int          compared = 0, mismatched = 0;
    int          cyc = 0, last_evt = 0, conflicts = 0, valids_seen = 0;
    logic        prev_we = 1'b1;
    logic [17:0] w_a;
    logic [15:0] w_d;
    wr_t         wm;
    ev_t         em;

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h2A5B};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_w.exists(int'(a)) ? ref_w[int'(a)] : pat(a);
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always_comb sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];

    // monitor: SRAM write capture, bus-conflict watch, and scoreboard pop on ready/valid
    always @(negedge clk) begin
        cyc++;
        if (reset) prev_we = 1'b1;
        else begin
            if (!sram_oe_n && sram_dq_oe) conflicts++;
            if (!sram_we_n) begin
                w_a = sram_addr;
                w_d = sram_dq_out;
                if (!sram_dq_oe) conflicts++;
            end
            if (!prev_we && sram_we_n) begin
                sram[w_a] = w_d;
                if (expw_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    wm = expw_q.pop_front();
                    chk("wr_addr", w_a, wm.a);
                    chk("wr_data", w_d, wm.d);
                end
            end
            prev_we = sram_we_n;
            if (mem_ready || mem_valid) begin
                if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
                else begin
                    em = exp_q.pop_front();
                    chk("event_kind", mem_ready ? 0 : 1, em.kind == 0 ? 0 : 1);
                    if (mem_ready) chk("ce_n_busy", sram_ce_n, 0);
                    if (em.kind != 0) chk("offset", mem_offset, em.off);
                    if (em.kind == 1) chk("rd_data", from_mem, em.data);
                    if (em.kind == 2 && fifo.size() != 0) begin
                        void'(fifo.pop_front());
                        to_mem = fifo.size() != 0 ? fifo[0] : 16'h0;
                    end
                    if (em.lat >= 0) chk("latency", cyc - last_evt, em.lat);
                end
                last_evt = cyc;
                if (mem_valid) valids_seen++;
            end
        end
    end

    task automatic issue(input logic [17:0] b, input logic wr, input int rlat, input logic keep, input logic [15:0] d0, input logic rnd);
        ev_t e;
        wr_t w;
        int n;
        e.kind = 0; e.off = 0; e.data = 0; e.lat = rlat;
        exp_q.push_back(e);
        for (int i = 0; i < BL; i++) begin
            w.a = b + 18'(i);
            if (wr) begin
                w.d = rnd ? 16'($urandom) : d0 + 16'(i);
                ref_w[int'(w.a)] = w.d;
                expw_q.push_back(w);
                fifo.push_back(w.d);
                e.kind = 2; e.off = (i + 1) % 8; e.data = 0; e.lat = WS + 3;
            end else begin
                e.kind = 1; e.off = i; e.data = ref_rd(w.a); e.lat = (i == 0) ? WS + 4 : WS + 3;
            end
            exp_q.push_back(e);
        end
        to_mem = fifo.size() != 0 ? fifo[0] : 16'h0;
        mem_address = {14'd0, b};
        mem_wren = wr;
        mem_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 300);
        if (!mem_ready) chk("ready_timeout", 0, 1);
        if (!keep) mem_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || expw_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size() + expw_q.size(), 0);
        chk("ce_n_idle", sram_ce_n, CE_IDLE);
    endtask

    initial begin
        int n, vs;
        logic pk, pw, wr, keep;
        logic [17:0] b;
        reset = 1'b1; mem_req = 1'b0; mem_wren = 1'b0; mem_address = '0; to_mem = '0;
        for (int i = 0; i < 262144; i++) sram[i] = pat(18'(i));
        repeat (3) @(negedge clk);
        chk("rst_from_mem", from_mem, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_offset", mem_offset, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_ub_n", sram_ub_n, 0);
        chk("rst_lb_n", sram_lb_n, 0);
        chk("rst_ce_n", sram_ce_n, CE_IDLE);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        // directed write, read-back, wrap and back-to-back bursts
        issue(18'h00100, 1'b1, -1, 1'b0, 16'hA000, 1'b0);
        drain();
        issue(18'h00100, 1'b0, -1, 1'b0, 16'h0, 1'b0);
        drain();
        issue(18'h3FFFC, 1'b0, -1, 1'b0, 16'h0, 1'b0);
        drain();
        issue(18'h00010, 1'b0, -1, 1'b1, 16'h0, 1'b0);
        issue(18'h00018, 1'b0, 1, 1'b0, 16'h0, 1'b0);
        drain();
        // abort a write burst with reset during the strobe of word 3
        issue(18'h20000, 1'b1, -1, 1'b0, 16'hC000, 1'b0);
        n = 0;
        while (!(exp_q.size() == 5 && !sram_we_n) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", n < 300, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_dq_oe", sram_dq_oe, 0);
        chk("abort_valid", mem_valid, 0);
        exp_q.delete(); expw_q.delete(); fifo.delete(); to_mem = '0;
        vs = valids_seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("valid_after_abort", valids_seen - vs, 0);
        chk("ce_n_after_abort", sram_ce_n, CE_IDLE);
        // randomized bursts, some chained back-to-back
        pk = 1'b0; pw = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 5) == 0) ? 18'h3FFF8 + 18'($urandom_range(0, 7)) : 18'($urandom_range(0, 16'hFFFF));
            keep = (i < 23) && ($urandom_range(0, 2) == 0);
            issue(b, wr, pk ? (pw ? 2 : 1) : -1, keep, 16'h0, 1'b1);
            if (!keep) begin
                drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            pk = keep; pw = wr;
        end
        drain();
        chk("bus_conflicts", conflicts, 0);
        chk("fifo_left", fifo.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
